// File: rtl/y86_fetch_unit_if.sv
// y86_fetch_unit_if
//   Groups the fetch unit's buses: the PC-update load port, the byte-wide
//   instruction memory request/ack bus, and the valid/ready hand-off of a
//   decoded instruction to the decode stage.
//   master : the fetch unit side
//   slave  : the environment side (PC update, instruction memory, decode)
//
//   pc_in/pc_load          next PC from PC update
//   imem_req/imem_addr     byte read request and address
//   imem_ack/imem_rdata    returned byte, qualified by imem_ack
//   imem_err               address error, qualified by imem_ack
//   out_valid/out_ready    instruction hand-off to decode
//   icode/ifun/rA/rB/valC  instruction fields
//   valP/stat/pc           next sequential PC, status, current PC register
interface y86_fetch_unit_if;
    logic [63:0] pc_in;
    logic        pc_load;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_rdata;
    logic        imem_err;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [2:0]  stat;
    logic [63:0] pc;

    modport master (
        input  pc_in, pc_load, imem_ack, imem_rdata, imem_err, out_ready,
        output imem_req, imem_addr, out_valid, icode, ifun, rA, rB,
               valC, valP, stat, pc
    );

    modport slave (
        output pc_in, pc_load, imem_ack, imem_rdata, imem_err, out_ready,
        input  imem_req, imem_addr, out_valid, icode, ifun, rA, rB,
               valC, valP, stat, pc
    );
endinterface

// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit
//   Y86-64 fetch stage. Holds the architectural PC, reads the instruction at
//   that PC one byte per accepted memory transfer, splits it into fields,
//   computes valP and offers the result to decode. After decode takes an AOK
//   instruction it waits for PC update to load the next PC; any other status
//   parks the unit until reset.
//
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    y86_fetch_unit_if.master (memory bus, decode hand-off, PC load)
//
//   state   | meaning
//   FETCH   | requesting instruction bytes at pc + byte_cnt
//   VALID   | instruction offered to decode, outputs frozen
//   WAIT_PC | instruction taken, waiting for pc_load
//   HALTED  | non-AOK instruction taken; only reset leaves
module y86_fetch_unit (
    input  logic             clk,
    input  logic             rst_n,
    y86_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        VALID   = 2'd1,
        WAIT_PC = 2'd2,
        HALTED  = 2'd3
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        logic [3:0] len;
        case (ic)
            4'h0, 4'h1, 4'h9:       len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
            4'h7, 4'h8:             len = 4'd9;
            4'h3, 4'h4, 4'h5:       len = 4'd10;
            default:                len = 4'd1;
        endcase
        return len;
    endfunction

    state_t      state;
    logic [3:0]  byte_cnt;
    logic [3:0]  ilen;
    logic [63:0] pc_r;
    logic [63:0] addr_r;
    logic        req_r;
    logic        valid_r;
    logic [3:0]  icode_r;
    logic [3:0]  ifun_r;
    logic [3:0]  ra_r;
    logic [3:0]  rb_r;
    logic [63:0] valc_r;
    logic [63:0] valp_r;
    logic [2:0]  stat_r;

    logic [3:0]  len0;
    logic [3:0]  cur_len;
    logic        last_byte;
    logic        valc_hit;
    logic [2:0]  valc_idx;

    // Byte 0 decides the length in the same cycle it arrives, so a 1-byte
    // instruction completes without an extra cycle.
    always_comb begin
        len0      = instr_len(bus.imem_rdata[7:4]);
        cur_len   = (byte_cnt == 4'd0) ? len0 : ilen;
        last_byte = (byte_cnt == cur_len - 4'd1);
        valc_hit  = 1'b0;
        valc_idx  = 3'd0;
        if (ilen == 4'd9 && byte_cnt != 4'd0) begin
            valc_hit = 1'b1;
            valc_idx = byte_cnt[2:0] - 3'd1;
        end else if (ilen == 4'd10 && byte_cnt >= 4'd2) begin
            valc_hit = 1'b1;
            // byte 9 wraps byte_cnt[2:0] to 1, and 1 - 2 wraps to 7 as needed
            valc_idx = byte_cnt[2:0] - 3'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            byte_cnt <= 4'd0;
            ilen     <= 4'd1;
            pc_r     <= 64'd0;
            addr_r   <= 64'd0;
            req_r    <= 1'b0;
            valid_r  <= 1'b0;
            icode_r  <= 4'h0;
            ifun_r   <= 4'h0;
            ra_r     <= 4'hF;
            rb_r     <= 4'hF;
            valc_r   <= 64'd0;
            valp_r   <= 64'd0;
            stat_r   <= STAT_AOK;
        end else begin
            case (state)
                FETCH: begin
                    if (!req_r) begin
                        // only reached on the first cycle out of reset
                        req_r <= 1'b1;
                    end else if (bus.imem_ack) begin
                        if (bus.imem_err) begin
                            stat_r  <= STAT_ADR;
                            req_r   <= 1'b0;
                            valid_r <= 1'b1;
                            state   <= VALID;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                            addr_r   <= addr_r + 64'd1;
                            if (byte_cnt == 4'd0) begin
                                icode_r <= bus.imem_rdata[7:4];
                                ifun_r  <= bus.imem_rdata[3:0];
                                ilen    <= len0;
                                valp_r  <= pc_r + {60'd0, len0};
                                if (bus.imem_rdata[7:4] == 4'h0)
                                    stat_r <= STAT_HLT;
                                else if (bus.imem_rdata[7:4] > 4'hB)
                                    stat_r <= STAT_INS;
                            end else if (valc_hit) begin
                                valc_r[{valc_idx, 3'b000} +: 8] <= bus.imem_rdata;
                            end else if (byte_cnt == 4'd1) begin
                                ra_r <= bus.imem_rdata[7:4];
                                rb_r <= bus.imem_rdata[3:0];
                            end
                            if (last_byte) begin
                                req_r   <= 1'b0;
                                valid_r <= 1'b1;
                                state   <= VALID;
                            end
                        end
                    end
                end
                VALID: begin
                    if (bus.out_ready) begin
                        valid_r <= 1'b0;
                        state   <= (stat_r == STAT_AOK) ? WAIT_PC : HALTED;
                    end
                end
                WAIT_PC: begin
                    if (bus.pc_load) begin
                        pc_r     <= bus.pc_in;
                        addr_r   <= bus.pc_in;
                        byte_cnt <= 4'd0;
                        ilen     <= 4'd1;
                        req_r    <= 1'b1;
                        icode_r  <= 4'h0;
                        ifun_r   <= 4'h0;
                        ra_r     <= 4'hF;
                        rb_r     <= 4'hF;
                        valc_r   <= 64'd0;
                        // an address error on byte 0 leaves valP at the PC
                        valp_r   <= bus.pc_in;
                        stat_r   <= STAT_AOK;
                        state    <= FETCH;
                    end
                end
                HALTED: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_r;
    assign bus.imem_addr = addr_r;
    assign bus.out_valid = valid_r;
    assign bus.icode     = icode_r;
    assign bus.ifun      = ifun_r;
    assign bus.rA        = ra_r;
    assign bus.rB        = rb_r;
    assign bus.valC      = valc_r;
    assign bus.valP      = valp_r;
    assign bus.stat      = stat_r;
    assign bus.pc        = pc_r;

endmodule

// File: tb/tb_y86_fetch_unit.sv
module tb_y86_fetch_unit;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
        logic [2:0]  stat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    y86_fetch_unit_if bus();

    y86_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  mem [logic [63:0]];
    logic [7:0]  ib [10];
    exp_t        exp_q [$];
    exp_t        last_e;

    logic [63:0] req_log [$];
    logic [63:0] stall_addrs [$];
    int          stall_seen = 0;
    int          log_mark = 0;
    int          stall_mark = 0;
    int          stall_idx = -1;
    int          stall_len = 0;
    int          err_idx = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [7:0] rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    // memory responder: drives ack/data on the falling edge
    always @(negedge clk) begin
        int acc;
        acc = req_log.size() - log_mark;
        bus.imem_ack   = 1'b0;
        bus.imem_err   = 1'b0;
        bus.imem_rdata = 8'h00;
        if (rst_n && bus.imem_req) begin
            if (acc == stall_idx && (stall_seen - stall_mark) < stall_len) begin
                stall_seen++;
                stall_addrs.push_back(bus.imem_addr);
            end else begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = rd(bus.imem_addr);
                bus.imem_err   = (acc == err_idx);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.imem_req && bus.imem_ack && !bus.imem_err)
            req_log.push_back(bus.imem_addr);
    end

    function automatic exp_t model(input logic [63:0] pc, input int ei);
        exp_t e;
        int len;
        int vs;
        e.icode = ib[0][7:4];
        e.ifun  = ib[0][3:0];
        e.rA    = 4'hF;
        e.rB    = 4'hF;
        e.valC  = 64'd0;
        case (ib[0][7:4])
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            4'h3, 4'h4, 4'h5:       len = 10;
            default:                len = 1;
        endcase
        if ((len == 2 || len == 10) && (ei < 0 || ei > 1)) begin
            e.rA = ib[1][7:4];
            e.rB = ib[1][3:0];
        end
        vs = (len == 9) ? 1 : 2;
        if (len >= 9)
            for (int k = 0; k < 8; k++)
                if (ei < 0 || vs + k < ei) e.valC[8*k +: 8] = ib[vs + k];
        e.valP = pc + 64'(len);
        if (ei >= 0 && ei < len)  e.stat = 3'd3;
        else if (e.icode == 4'h0) e.stat = 3'd2;
        else if (e.icode > 4'hB)  e.stat = 3'd4;
        else                      e.stat = 3'd1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},   64'(bus.imem_req), 64'd0);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_pc"},    bus.pc, 64'd0);
        chk({tag, "_icode"}, 64'(bus.icode), 64'd0);
        chk({tag, "_ifun"},  64'(bus.ifun), 64'd0);
        chk({tag, "_rA"},    64'(bus.rA), 64'hF);
        chk({tag, "_rB"},    64'(bus.rB), 64'hF);
        chk({tag, "_valC"},  bus.valC, 64'd0);
        chk({tag, "_valP"},  bus.valP, 64'd0);
        chk({tag, "_stat"},  64'(bus.stat), 64'd1);
    endtask

    task automatic expect_instr(input string tag, input int lat);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_size"}, 64'(exp_q.size()), 64'd1);
        end else begin
            last_e = exp_q.pop_front();
            chk({tag, "_icode"}, 64'(bus.icode), 64'(last_e.icode));
            chk({tag, "_ifun"},  64'(bus.ifun), 64'(last_e.ifun));
            chk({tag, "_rA"},    64'(bus.rA), 64'(last_e.rA));
            chk({tag, "_rB"},    64'(bus.rB), 64'(last_e.rB));
            chk({tag, "_valC"},  bus.valC, last_e.valC);
            chk({tag, "_valP"},  bus.valP, last_e.valP);
            chk({tag, "_stat"},  64'(bus.stat), 64'(last_e.stat));
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // reset, then consume the nop that lives at address 0
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset(tag);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        chk({tag, "_req_pre"}, 64'(bus.imem_req), 64'd0);
        ib = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back(model(64'd0, -1));
        log_mark = req_log.size();
        tick();
        chk({tag, "_req_rise"}, 64'(bus.imem_req), 64'd1);
        chk({tag, "_addr0"}, bus.imem_addr, 64'd0);
        expect_instr({tag, "_nop"}, 1);
        accept();
    endtask

    task automatic issue(input logic [63:0] pc, input int n, input int ei);
        for (int i = 0; i < n; i++) mem[pc + 64'(i)] = ib[i];
        exp_q.push_back(model(pc, ei));
        err_idx = ei;
        bus.pc_in = pc;
        bus.pc_load = 1'b1;
        log_mark = req_log.size();
        tick();
        bus.pc_load = 1'b0;
    endtask

    initial begin
        bus.pc_in     = 64'd0;
        bus.pc_load   = 1'b0;
        bus.out_ready = 1'b0;
        mem[64'd0]    = 8'h10;
        #2;
        do_reset("rst1");

        // irmovq at 0x100, zero-wait
        ib = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        issue(64'h100, 10, -1);
        expect_instr("irmovq", 10);
        chk("irmovq_nreq", 64'(req_log.size() - log_mark), 64'd10);
        for (int i = 0; i < 10 && log_mark + i < req_log.size(); i++)
            chk("irmovq_addr", req_log[log_mark + i], 64'h100 + 64'(i));
        chk("irmovq_pc", bus.pc, 64'h100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_valC", bus.valC, last_e.valC);
            chk("bp_valP", bus.valP, last_e.valP);
            chk("bp_rB", 64'(bus.rB), 64'(last_e.rB));
            chk("bp_req", 64'(bus.imem_req), 64'd0);
        end
        accept();

        // call with 3 stall cycles on byte 4
        ib = '{8'h80, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        stall_mark = stall_seen;
        stall_idx  = 4;
        stall_len  = 3;
        issue(64'h200, 9, -1);
        expect_instr("call", 12);
        chk("call_nstall", 64'(stall_addrs.size()), 64'd3);
        foreach (stall_addrs[i]) chk("call_stall_addr", stall_addrs[i], 64'h204);
        stall_idx = -1;
        accept();

        // OPq
        ib = '{8'h60, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        issue(64'h400, 2, -1);
        expect_instr("opq", 2);
        accept();

        // invalid instruction, then HALTED ignores pc_load
        ib = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        issue(64'h20, 1, -1);
        expect_instr("ins", 1);
        accept();
        bus.pc_in = 64'h40;
        bus.pc_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_req", 64'(bus.imem_req), 64'd0);
            chk("halt_valid", 64'(bus.out_valid), 64'd0);
        end
        bus.pc_load = 1'b0;
        chk("halt_pc", bus.pc, 64'h20);

        // address error on byte 2 of mrmovq
        do_reset("rst2");
        ib = '{8'h50, 8'h12, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        issue(64'h300, 10, 2);
        expect_instr("adr", 3);
        err_idx = -1;
        accept();
        tick();
        chk("adr_halt_req", 64'(bus.imem_req), 64'd0);

        // reset in the middle of a 10-byte fetch
        do_reset("rst3");
        ib = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        issue(64'h100, 10, -1);
        for (int i = 0; i < 4; i++) tick();
        #2;
        do_reset("midrst");

        // PC wrap: nop at the top of the address space
        ib = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        issue(64'hFFFF_FFFF_FFFF_FFFF, 1, -1);
        expect_instr("wrap", 1);
        accept();

        // halt
        ib = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        issue(64'h500, 1, -1);
        expect_instr("hlt", 1);
        accept();
        tick();
        chk("hlt_halt_req", 64'(bus.imem_req), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
